// File: rtl/dispatch_pkg.sv
// Shared types and widths for the block dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Block index and kernel thread-count widths (control register is 8 bits)
  localparam int BID_W     = 8;
  localparam int TCNT_IN_W = 8;

  // Per-block active-thread width: must hold the value THREADS_PER_BLOCK itself
  function automatic int tc_w(input int tpb);
    return $clog2(tpb) + 1;
  endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Core-side bus: per-core run flags, block ids and thread counts, plus done flags back.
// Latency: n/a (wiring only).
// Backpressure: a core stays busy (core_start held) until it raises core_done.
import dispatch_pkg::*;

interface block_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int TC_W      = 3
);
  logic [NUM_CORES-1:0]            core_start;
  logic [NUM_CORES-1:0]            core_done;
  logic [NUM_CORES-1:0][BID_W-1:0] core_block_id;
  logic [NUM_CORES-1:0][TC_W-1:0]  core_thread_count;

  // Dispatcher side
  modport master (
    output core_start, core_block_id, core_thread_count,
    input  core_done
  );

  // Core-array side
  modport slave (
    input  core_start, core_block_id, core_thread_count,
    output core_done
  );
endinterface

// File: rtl/dispatch_pick.sv
// Priority encoder: index of the lowest set bit of i_free, with a valid flag.
// Latency: combinational.
// Backpressure: none; o_vld low when no core is free.
import dispatch_pkg::*;

module dispatch_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_free,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  // Scan downward so the lowest free index is the last one written
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel into blocks of THREADS_PER_BLOCK and hands one block per cycle to the lowest idle core.
// Latency: launch edge enters RUN, first assignment on the next edge; done one cycle after the last completion.
// Backpressure: a core is reused only after its core_done is honoured; optional DISPATCH_PERF_EN adds kernel_cycles.
import dispatch_pkg::*;

module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TCNT_IN_W-1:0] thread_count,
  block_dispatcher_if.master   core_if,
`ifdef DISPATCH_PERF_EN
  output logic [15:0]          kernel_cycles,
`endif
  output logic                 done
);

  localparam int TC_W     = tc_w(THREADS_PER_BLOCK);
  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t                          r_state, w_state_nxt;
  logic [TCNT_IN_W-1:0]            r_latched, w_latched_nxt;
  logic [BID_W-1:0]                r_total, w_total_nxt;
  logic [BID_W-1:0]                r_disp, w_disp_nxt;
  logic [BID_W-1:0]                r_comp, w_comp_nxt;
  logic [NUM_CORES-1:0]            r_core_start, w_core_start_nxt;
  logic [NUM_CORES-1:0][BID_W-1:0] r_bid, w_bid_nxt;
  logic [NUM_CORES-1:0][TC_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic                            r_done, w_done_nxt;
  logic [15:0]                     r_kcyc, w_kcyc_nxt;

  logic [NUM_CORES-1:0] w_done_mask;
  logic [BID_W-1:0]     w_ndone;
  logic [BID_W-1:0]     w_comp_sum;
  logic [15:0]          w_round_up;
  logic [BID_W-1:0]     w_launch_total;
  logic [15:0]          w_last_rem;
  logic                 w_pick_vld;
  logic [IDX_W-1:0]     w_pick_idx;

  dispatch_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_pick (
    .i_free (~r_core_start),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  // Done flags from idle cores are masked off; count the honoured ones
  always_comb begin
    w_done_mask = core_if.core_done & r_core_start;
    w_ndone     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_ndone = w_ndone + BID_W'(w_done_mask[i]);
    end
    w_comp_sum     = r_comp + w_ndone;
    w_round_up     = 16'(thread_count) + 16'(THREADS_PER_BLOCK - 1);
    w_launch_total = BID_W'(w_round_up >> LOG2_TPB);
    w_last_rem     = 16'(r_latched) - (16'(r_disp) << LOG2_TPB);
  end

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    w_state_nxt      = r_state;
    w_latched_nxt    = r_latched;
    w_total_nxt      = r_total;
    w_disp_nxt       = r_disp;
    w_comp_nxt       = r_comp;
    w_core_start_nxt = r_core_start;
    w_bid_nxt        = r_bid;
    w_tcnt_nxt       = r_tcnt;
    w_done_nxt       = r_done;
    w_kcyc_nxt       = r_kcyc;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_latched_nxt = thread_count;
          w_total_nxt   = w_launch_total;
          w_disp_nxt    = '0;
          w_comp_nxt    = '0;
          w_kcyc_nxt    = '0;
          if (thread_count == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (r_kcyc != 16'hFFFF) begin
          w_kcyc_nxt = r_kcyc + 16'd1;
        end
        // Cores freed this edge are not in the free mask until next edge
        w_core_start_nxt = r_core_start & ~w_done_mask;
        w_comp_nxt       = w_comp_sum;
        if ((r_disp < r_total) && w_pick_vld) begin
          w_core_start_nxt[w_pick_idx] = 1'b1;
          w_bid_nxt[w_pick_idx]        = r_disp;
          w_tcnt_nxt[w_pick_idx]       = (r_disp == r_total - BID_W'(1)) ?
                                         TC_W'(w_last_rem) : TC_W'(THREADS_PER_BLOCK);
          w_disp_nxt                   = r_disp + BID_W'(1);
        end
        if (w_comp_sum == r_total) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything mid-kernel too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_latched    <= '0;
      r_total      <= '0;
      r_disp       <= '0;
      r_comp       <= '0;
      r_core_start <= '0;
      r_bid        <= '0;
      r_tcnt       <= '0;
      r_done       <= 1'b0;
      r_kcyc       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_latched    <= w_latched_nxt;
      r_total      <= w_total_nxt;
      r_disp       <= w_disp_nxt;
      r_comp       <= w_comp_nxt;
      r_core_start <= w_core_start_nxt;
      r_bid        <= w_bid_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_done       <= w_done_nxt;
      r_kcyc       <= w_kcyc_nxt;
    end
  end

  assign core_if.core_start        = r_core_start;
  assign core_if.core_block_id     = r_bid;
  assign core_if.core_thread_count = r_tcnt;
  assign done                      = r_done;
`ifdef DISPATCH_PERF_EN
  assign kernel_cycles = r_kcyc;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench with a scoreboard: expected core assignments and kernel completions are queued
// by the stimulus; a forked monitor pops and compares on every core_start / done rising edge.
// Optional DISPATCH_PERF_EN checks of kernel_cycles are compiled in when the macro is defined.
module tb_block_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] thread_count;
  logic       done;
`ifdef DISPATCH_PERF_EN
  logic [15:0] kernel_cycles;
`endif

  always #5 clk = ~clk;

  block_dispatcher_if #(.NUM_CORES(2), .TC_W(3)) bus ();

  block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_count (thread_count),
    .core_if      (bus.master),
`ifdef DISPATCH_PERF_EN
    .kernel_cycles(kernel_cycles),
`endif
    .done         (done)
  );

  typedef struct {
    int core;
    int bid;
    int tc;
  } asg_t;

  asg_t asg_q[$];
  int   done_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [1:0] prev_cs;
  logic       prev_done;
  int         n_asg;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_asg(input int c, input int b, input int t);
    asg_t a;
    a.core = c; a.bid = b; a.tc = t;
    asg_q.push_back(a);
  endtask

  task automatic wait_start(input int c);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.core_start[c]) return;
    end
    check("wait_core_start_timeout", int'(bus.core_start[c]), 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) return;
    end
    check("wait_done_timeout", int'(done), 1);
  endtask

  task automatic pulse_done(input logic [1:0] m);
    @(negedge clk);
    bus.core_done = m;
    @(negedge clk);
    bus.core_done = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    thread_count = 8'd0;
    bus.core_done = 2'b00;
    prev_cs = 2'b00;
    prev_done = 1'b0;
    n_asg = 0;

    // Monitor: compare every assignment and completion against the scoreboard
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          prev_cs = 2'b00;
          prev_done = 1'b0;
          n_asg = 0;
        end else begin
          for (int c = 0; c < 2; c++) begin
            if (bus.core_start[c] && !prev_cs[c]) begin
              if (asg_q.size() == 0) begin
                check("unexpected_core_start", c, -1);
              end else begin
                asg_t e;
                e = asg_q.pop_front();
                check("asg_core", c, e.core);
                check("asg_block_id", int'(bus.core_block_id[c]), e.bid);
                check("asg_thread_count", int'(bus.core_thread_count[c]), e.tc);
                n_asg++;
              end
            end
          end
          if (done && !prev_done) begin
            if (done_q.size() == 0) check("unexpected_done", n_asg, -1);
            else check("blocks_before_done", n_asg, done_q.pop_front());
            n_asg = 0;
          end
          prev_cs = bus.core_start;
          prev_done = done;
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_core_start", int'(bus.core_start), 0);
    check("rst_block_id", int'(bus.core_block_id), 0);
    check("rst_thread_count", int'(bus.core_thread_count), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b1;
    @(negedge clk);

    // 10 threads: blocks 0,1 to cores 0,1; block 2 (2 threads) to freed core 0
    thread_count = 8'd10;
    start = 1'b1;
    push_asg(0, 0, 4); push_asg(1, 1, 4); push_asg(0, 2, 2);
    done_q.push_back(3);
    wait_start(0);
    thread_count = 8'd3;
    wait_start(1);
    pulse_done(2'b01);
    wait_start(0);
    check("t10_busy_both", int'(bus.core_start), 3);
    pulse_done(2'b11);
    wait_done();
    check("t10_done", int'(done), 1);
    start = 1'b0;
    @(negedge clk);
    check("t10_done_clear", int'(done), 0);

    // Zero threads: straight to done, no core started
    thread_count = 8'd0;
    start = 1'b1;
    done_q.push_back(0);
    wait_done();
    check("t0_done", int'(done), 1);
    check("t0_no_start", int'(bus.core_start), 0);
    start = 1'b0;
    @(negedge clk);
    check("t0_done_clear", int'(done), 0);

    // 8 threads, both cores finish on the same edge -> done next cycle
    thread_count = 8'd8;
    start = 1'b1;
    push_asg(0, 0, 4); push_asg(1, 1, 4);
    done_q.push_back(2);
    wait_start(1);
    bus.core_done = 2'b11;
    @(negedge clk);
    check("t8_done_next_cycle", int'(done), 1);
    check("t8_cores_freed", int'(bus.core_start), 0);
    bus.core_done = 2'b00;
    start = 1'b0;
    @(negedge clk);

    // 4 threads, stray done on idle core 1 is ignored
    thread_count = 8'd4;
    start = 1'b1;
    push_asg(0, 0, 4);
    done_q.push_back(1);
    wait_start(0);
    pulse_done(2'b10);
    check("idle_done_no_finish", int'(done), 0);
    check("idle_done_core_start", int'(bus.core_start), 1);
    repeat (3) @(negedge clk);
    check("idle_done_still_running", int'(done), 0);
    pulse_done(2'b01);
    wait_done();
    start = 1'b0;
    @(negedge clk);

    // Reset mid-RUN clears all outputs immediately
    thread_count = 8'd10;
    start = 1'b1;
    push_asg(0, 0, 4); push_asg(1, 1, 4);
    wait_start(1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_core_start", int'(bus.core_start), 0);
    check("midrst_block_id", int'(bus.core_block_id), 0);
    check("midrst_thread_count", int'(bus.core_thread_count), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clean 4-thread kernel after reset; core_done 5 cycles after core_start
    thread_count = 8'd4;
    start = 1'b1;
    push_asg(0, 0, 4);
    done_q.push_back(1);
    wait_start(0);
    repeat (4) @(negedge clk);
    bus.core_done = 2'b01;
    @(negedge clk);
    bus.core_done = 2'b00;
    check("post_rst_done", int'(done), 1);
`ifdef DISPATCH_PERF_EN
    check("kernel_cycles", int'(kernel_cycles), 6);
    repeat (3) @(negedge clk);
    check("kernel_cycles_held", int'(kernel_cycles), 6);
`endif
    start = 1'b0;
    @(negedge clk);
    check("post_rst_done_clear", int'(done), 0);

    repeat (2) @(negedge clk);
    check("asg_q_drained", asg_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_dispatcher.md
BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, the maximum number of threads per block; it SHALL be a power of two.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, kernel launch request (level).
REQ-006 SHALL have port thread_count, input, 8, total kernel threads from the device control register.
REQ-007 SHALL have port core_done, input, NUM_CORES, per-core block-complete flags.
REQ-008 SHALL have port core_start, output, NUM_CORES, per-core block-run flags, held until done.
REQ-009 SHALL have port core_block_id, output, NUM_CORES x 8, block index assigned to each core.
REQ-010 SHALL have port core_thread_count, output, NUM_CORES x ($clog2(THREADS_PER_BLOCK)+1), active threads in each assigned block.
REQ-011 SHALL have port done, output, 1, kernel-complete flag.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; all outputs are registered.
REQ-013 IDLE: when start=1, SHALL latch thread_count, compute total_blocks = ceil(thread_count/THREADS_PER_BLOCK), clear the dispatched and completed counters, and go to RUN.
REQ-014 IDLE with start=1 and thread_count=0 SHALL go directly to DONE without asserting any core_start.
REQ-015 RUN: on each edge where dispatched<total_blocks and at least one core has core_start=0, the lowest-index such core SHALL be assigned (core_start<=1, core_block_id<=dispatched, dispatched+1); at most one assignment per cycle.
REQ-016 core_thread_count SHALL be THREADS_PER_BLOCK for every block except the last, which SHALL receive latched_count - block_id*THREADS_PER_BLOCK.
REQ-017 core_done[i] SHALL be honoured only while core_start[i]=1; it then clears core_start[i] and increments completed. core_done on an idle core SHALL be ignored.
REQ-018 Multiple simultaneous core_done SHALL all be counted on the same edge.
REQ-019 A core freed on edge N SHALL be eligible for assignment no earlier than edge N+1.
REQ-020 When completed reaches total_blocks, the FSM SHALL enter DONE on that edge; done=1 from the following cycle.
REQ-021 DONE: done SHALL hold 1 until start=0 is sampled, then the FSM returns to IDLE with done<=0.
REQ-022 start changes and thread_count changes during RUN SHALL be ignored; thread_count is used only as latched.

Reset
REQ-023 reset=0 SHALL immediately force IDLE and clear core_start, core_block_id, core_thread_count, done, all counters and the latched count to 0, including in the middle of a kernel.

Configuration
REQ-024 With DISPATCH_PERF_EN defined, SHALL add output kernel_cycles[15:0], counting cycles spent in RUN, saturating at 16'hFFFF, held in DONE, cleared on launch and reset.
REQ-025 Without DISPATCH_PERF_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-026 The package dispatch_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the block-id and thread-count width constants.
REQ-027 Lowest-free-core selection SHALL be a sub-module dispatch_pick, a combinational priority encoder that outputs a valid flag and an index.

Verification
REQ-028 thread_count=10, NUM_CORES=2, TPB=4, start -> block0 goes to core0 (4 threads) then block1 to core1 (4 threads); after the first core_done, block2 goes to the freed core (2 threads); after 3 dones, done=1.
REQ-029 thread_count=0, start -> done=1 with no core_start ever asserted.
REQ-030 thread_count=8 with both cores done on the same cycle -> completed=2 and done=1 on the next cycle.
REQ-031 reset pulsed low mid-RUN -> all outputs 0 immediately; a subsequent start with thread_count=4 runs cleanly (one block, 4 threads, core0).
REQ-032 core_done[1] pulsed while core1 is idle -> no count change; done does not assert early.
REQ-033 DISPATCH_PERF_EN with thread_count=4 and core_done 5 cycles after core_start -> kernel_cycles equals the RUN residency and is held in DONE.
